// File: rtl/alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq
//
// Purpose:
//   Multi-cycle 32x32 unsigned multiply / unsigned divide sequencer. It does
//   not contain its own adder. Instead it borrows the shared combinational
//   ALU beside the execute stage, and uses only the ADD, SUB and SLTU
//   operations. Shifts and iteration bookkeeping are done internally.
//
//   Each of the 32 iterations takes two cycles (phase 0 / phase 1), so a
//   normal operation keeps busy high for exactly 64 cycles. That is followed
//   by a one-cycle done pulse. A divide by zero skips RUN entirely.
//
// Ports:
//   clk       in   1   clock, rising edge
//   rst       in   1   asynchronous active-high reset
//   start     in   1   request, sampled only in IDLE or DONE
//   op        in   1   0 = multiply, 1 = divide (captured with start)
//   a         in  32   multiplicand / dividend (captured with start)
//   b         in  32   multiplier / divisor (captured with start)
//   busy      out  1   high while computing
//   done      out  1   one-cycle pulse, hi/lo/div_zero valid
//   div_zero  out  1   divide had b == 0 (set together with done)
//   hi        out 32   product[63:32] / remainder
//   lo        out 32   product[31:0]  / quotient
//   alu_a     out 32   shared ALU operand A
//   alu_b     out 32   shared ALU operand B
//   alu_op    out  4   shared ALU operation select
//   alu_res   in  32   shared ALU result (combinational, same cycle)
// ---------------------------------------------------------------------------
module alu_muldiv_seq #(
  parameter logic [3:0] OP_ADD  = 4'd2,
  parameter logic [3:0] OP_SUB  = 4'd6,
  parameter logic [3:0] OP_SLTU = 4'd7,
  parameter logic [3:0] OP_IDLE = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_res
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Datapath registers. Multiply and divide never run at the same time, so
  // each register is shared between the two algorithms:
  //   acc_hi : PH (multiply)  / R  (divide)
  //   acc_lo : PL (multiply)  / Q  (divide)
  //   opnd   : M  (multiply)  / D  (divide)
  //   tmp    : S  (multiply)  / Rs (divide)
  //   tmp_lo : unused (mul)   / Qs (divide)
  logic        op_r;
  logic        phase;
  logic [4:0]  counter;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [31:0] opnd;
  logic [31:0] tmp;
  logic [31:0] tmp_lo;
  logic        msb;
  logic        lt;

  logic        accept;
  logic        last_step;
  logic        div_by_zero_req;
  logic [31:0] div_shift_hi;
  logic        div_take;
  logic [31:0] upd_hi;
  logic [31:0] upd_lo;

  // A start is honoured only when no operation is in flight. DONE counts as
  // "not in flight", which lets back-to-back requests chain without an idle
  // cycle in between.
  assign accept          = start && ((state == IDLE) || (state == DONE));
  assign div_by_zero_req = op && (b == 32'd0);
  assign last_step       = (state == RUN) && phase && (counter == 5'd31);

  // The divide shifts {R,Q} left by one. In phase 0 the shifted remainder
  // must already reach the ALU for the SLTU compare, so it is formed
  // combinationally here and also registered into tmp for phase 1.
  assign div_shift_hi = {acc_hi[30:0], acc_lo[31]};

  // Subtract when the shifted remainder overflowed 32 bits (msb) or is not
  // below the divisor.
  assign div_take = msb | ~lt;

  // Accumulator values at the end of phase 1. In a multiply, the carry out of
  // S = PH + addend is recovered as (S < PH) from the ALU's SLTU result and
  // becomes the new top bit as the 65-bit {carry,S,PL} shifts right by one.
  always_comb begin
    upd_hi = acc_hi;
    upd_lo = acc_lo;
    if (op_r) begin
      if (div_take) begin
        upd_hi = alu_res;
        upd_lo = {tmp_lo[31:1], 1'b1};
      end else begin
        upd_hi = tmp;
        upd_lo = tmp_lo;
      end
    end else begin
      upd_hi = {alu_res[0], tmp[31:1]};
      upd_lo = {tmp[0], acc_lo[31:1]};
    end
  end

  // State register. The asynchronous reset abandons any in-flight operation
  // immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A divide by zero is answered directly from the
  // request, so it goes straight to DONE without entering RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = div_by_zero_req ? DONE : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. The shared ALU is driven only while RUN is active. In every
  // other state, including reset, the ALU ports are parked at zero with the
  // idle opcode.
  always_comb begin
    busy   = (state == RUN);
    done   = (state == DONE);
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    alu_op = OP_IDLE;
    if (state == RUN) begin
      case ({op_r, phase})
        2'b00: begin
          alu_a  = acc_hi;
          alu_b  = acc_lo[0] ? opnd : 32'd0;
          alu_op = OP_ADD;
        end
        2'b01: begin
          alu_a  = tmp;
          alu_b  = acc_hi;
          alu_op = OP_SLTU;
        end
        2'b10: begin
          alu_a  = div_shift_hi;
          alu_b  = opnd;
          alu_op = OP_SLTU;
        end
        default: begin
          alu_a  = tmp;
          alu_b  = opnd;
          alu_op = OP_SUB;
        end
      endcase
    end
  end

  // Datapath and result registers. The operands are captured only when a
  // start is accepted, so changes on a/b/op during RUN have no effect.
  // hi/lo keep the last result until a new operation writes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r     <= 1'b0;
      phase    <= 1'b0;
      counter  <= 5'd0;
      acc_hi   <= 32'd0;
      acc_lo   <= 32'd0;
      opnd     <= 32'd0;
      tmp      <= 32'd0;
      tmp_lo   <= 32'd0;
      msb      <= 1'b0;
      lt       <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      div_zero <= 1'b0;
    end else if (accept) begin
      op_r     <= op;
      phase    <= 1'b0;
      counter  <= 5'd0;
      div_zero <= 1'b0;
      acc_hi   <= 32'd0;
      if (op) begin
        acc_lo <= a;
        opnd   <= b;
      end else begin
        acc_lo <= b;
        opnd   <= a;
      end
      if (div_by_zero_req) begin
        hi       <= a;
        lo       <= 32'hFFFF_FFFF;
        div_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      if (!phase) begin
        phase <= 1'b1;
        if (op_r) begin
          tmp    <= div_shift_hi;
          tmp_lo <= {acc_lo[30:0], 1'b0};
          msb    <= acc_hi[31];
          lt     <= alu_res[0];
        end else begin
          tmp <= alu_res;
        end
      end else begin
        phase   <= 1'b0;
        counter <= counter + 5'd1;
        acc_hi  <= upd_hi;
        acc_lo  <= upd_lo;
        if (last_step) begin
          hi <= upd_hi;
          lo <= upd_lo;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_muldiv_seq
//
// Directed bench for alu_muldiv_seq. It provides a behavioural model of the
// shared ALU. Expected results are queued when a request is issued, and a
// monitor pops and compares them on every done pulse. Latency, busy length,
// the ALU parking state and the reset behaviour are checked inline by the
// stimulus process.
// ---------------------------------------------------------------------------
module tb_alu_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_res;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];
  int   tests;
  int   fails;

  alu_muldiv_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_res  (alu_res)
  );

  // Shared ALU model with opcodes ADD=2, SUB=6, SLTU=7 and AND for
  // everything else.
  always_comb begin
    case (alu_op)
      4'd2:    alu_res = alu_a + alu_b;
      4'd6:    alu_res = alu_a - alu_b;
      4'd7:    alu_res = {31'd0, (alu_a < alu_b)};
      default: alu_res = alu_a & alu_b;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every done pulse must match the oldest queued
  // expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_done: got hi=%h lo=%h dz=%b, required no done", hi, lo, div_zero);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (hi !== e.hi || lo !== e.lo || div_zero !== e.dz) begin
          fails++;
          $display("[TB] FAIL result: got hi=%h lo=%h dz=%b, required hi=%h lo=%h dz=%b",
                   hi, lo, div_zero, e.hi, e.lo, e.dz);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, expv);
    end
  endtask

  // Issues one request. It returns one time unit after the accepting edge E0.
  task automatic applyStimulus(input logic o, input logic [31:0] av, input logic [31:0] bv,
                               input bit push, input logic [31:0] eh, input logic [31:0] el,
                               input logic ez);
    exp_t e;
    @(negedge clk);
    if (push) begin
      e.hi = eh;
      e.lo = el;
      e.dz = ez;
      exp_q.push_back(e);
    end
    op    = o;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts negedges until done is seen, up to a fixed budget. It also counts
  // busy cycles and notes whether the ALU ports stayed parked.
  task automatic wait_done(output int lat, output int busy_n, output bit alu_idle);
    lat      = 0;
    busy_n   = 0;
    alu_idle = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (alu_op != 4'd0 || alu_a != 32'd0 || alu_b != 32'd0) alu_idle = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL timeout: got no done in 200 cycles, required done");
    end
  endtask

  initial begin
    int lat;
    int bn;
    bit idle;
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = 32'd0;
    b     = 32'd0;

    repeat (2) @(negedge clk);
    checkOutput("reset_ctrl", {60'd0, busy, done, div_zero, 1'b0}, 64'd0);
    checkOutput("reset_hilo", {hi, lo}, 64'd0);
    checkOutput("reset_alu", {alu_a, alu_b}, 64'd0);
    checkOutput("reset_aluop", {60'd0, alu_op}, 64'd0);
    rst = 1'b0;

    // Multiply 7*6: latency, busy length and done deassertion.
    applyStimulus(1'b0, 32'd7, 32'd6, 1'b1, 32'd0, 32'd42, 1'b0);
    wait_done(lat, bn, idle);
    checkOutput("mul_latency", 64'(lat), 64'd65);
    checkOutput("mul_busy_cycles", 64'(bn), 64'd64);
    @(negedge clk);
    checkOutput("done_pulse_one_cycle", {63'd0, done}, 64'd0);

    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    wait_done(lat, bn, idle);

    applyStimulus(1'b1, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
    wait_done(lat, bn, idle);
    checkOutput("div_latency", 64'(lat), 64'd65);

    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 32'hFFFF_FFFF, 1'b0);
    wait_done(lat, bn, idle);

    // Divide by zero: immediate done, ALU never leaves idle.
    checkOutput("dz_alu_idle_pre", {28'd0, alu_op, alu_a}, 64'd0);
    applyStimulus(1'b1, 32'd123, 32'd0, 1'b1, 32'd123, 32'hFFFF_FFFF, 1'b1);
    wait_done(lat, bn, idle);
    checkOutput("dz_latency", 64'(lat), 64'd1);
    checkOutput("dz_busy_cycles", 64'(bn), 64'd0);
    checkOutput("dz_alu_idle", {63'd0, idle}, 64'd1);

    // A normal divide after a divide by zero must clear div_zero.
    applyStimulus(1'b1, 32'd5, 32'd9, 1'b1, 32'd5, 32'd0, 1'b0);
    wait_done(lat, bn, idle);

    // Start pulsed mid-run with new operands is ignored.
    applyStimulus(1'b0, 32'd1000, 32'd3000, 1'b1, 32'd0, 32'h002D_C6C0, 1'b0);
    repeat (9) @(negedge clk);
    op    = 1'b1;
    a     = 32'd5;
    b     = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = 32'd77;
    wait_done(lat, bn, idle);
    checkOutput("ignored_start_latency", 64'(lat), 64'd55);

    // Back-to-back: start held during DONE begins the next operation at once.
    applyStimulus(1'b0, 32'h8000_0000, 32'd2, 1'b1, 32'd1, 32'd0, 1'b0);
    wait_done(lat, bn, idle);
    exp_q.push_back('{hi: 32'd2, lo: 32'd14, dz: 1'b0});
    op    = 1'b1;
    a     = 32'd100;
    b     = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("b2b_busy", {62'd0, busy, done}, 64'd2);
    wait_done(lat, bn, idle);
    checkOutput("b2b_latency", 64'(lat), 64'd65);

    // Reset in the middle of a divide. No result is expected from it.
    applyStimulus(1'b1, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (29) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_ctrl", {60'd0, busy, done, div_zero, 1'b0}, 64'd0);
    checkOutput("midrst_hilo", {hi, lo}, 64'd0);
    checkOutput("midrst_alu", {28'd0, alu_op, alu_a | alu_b}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    applyStimulus(1'b0, 32'd3, 32'd5, 1'b1, 32'd0, 32'd15, 1'b0);
    wait_done(lat, bn, idle);
    checkOutput("post_rst_latency", 64'(lat), 64'd65);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that performs 32x32 unsigned multiply and unsigned divide by repeatedly driving the shared 32-bit combinational ALU.
- It uses the ALU's ADD, SUB and SLTU operations; shifts and bookkeeping are internal.
- It sits beside the CPU execute stage, owns the ALU operand/opcode inputs while busy, and returns a 64-bit {hi,lo} result with a start/busy/done handshake.

Parameters:
- OP_ADD, 4'd2, ALU opcode for A+B
- OP_SUB, 4'd6, ALU opcode for A-B
- OP_SLTU, 4'd7, ALU opcode for unsigned A<B (result bit 0)
- OP_IDLE, 4'd0, ALU opcode driven when idle (AND)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- op  in  1  0 = multiply, 1 = divide; captured with start
- a  in  32  multiplicand / dividend; captured with start
- b  in  32  multiplier / divisor; captured with start
- busy  out  1  high while computing
- done  out  1  one-cycle pulse; results valid
- div_zero  out  1  set with done when a divide had b==0
- hi  out  32  product[63:32] / remainder
- lo  out  32  product[31:0] / quotient
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_op  out  4  ALU operation select
- alu_res  in  32  ALU result, same cycle (combinational path)

Behaviour:
- All of the following hold in the asynchronous reset state (rst high, any time, including mid-operation):
  - state = IDLE; busy, done, div_zero = 0; hi = lo = 0; counter = 0.
  - alu_a = alu_b = 0; alu_op = OP_IDLE.
  - Any in-flight operation is abandoned.
- States are IDLE, RUN, DONE.
- IDLE/DONE, start=1 (accepted at edge E0):
  - Latch op, a, b; counter = 0; phase = 0; div_zero = 0.
  - Multiply: PH = 0, PL = b, M = a.
  - Divide: R = 0, Q = a, D = b.
  - b==0 on a divide: go to DONE at E0 with hi = a, lo = 32'hFFFFFFFF, div_zero = 1; done is high in the next cycle.
  - Otherwise go to RUN; busy = 1 from E0.
- start while in RUN is ignored; a, b, op changes during RUN have no effect.
- RUN runs 32 iterations of 2 cycles each (phase 0, phase 1), i.e. exactly 64 cycles. The counter increments after phase 1.
- Multiply, phase 0:
  - alu_a = PH, alu_b = PL[0] ? M : 0, alu_op = OP_ADD.
  - Latch S = alu_res.
- Multiply, phase 1:
  - alu_a = S, alu_b = PH, alu_op = OP_SLTU; carry = alu_res[0].
  - {PH,PL} <= {carry, S, PL[31:1]}.
- Divide, phase 0:
  - Shift {R,Q} left by 1 into registers: Rs = {R[30:0], Q[31]}, Qs = {Q[30:0], 0}, msb = R[31].
  - alu_a = Rs, alu_b = D, alu_op = OP_SLTU; latch lt = alu_res[0].
- Divide, phase 1:
  - alu_a = Rs, alu_b = D, alu_op = OP_SUB.
  - If msb | ~lt: R <= alu_res, Q <= {Qs[31:1], 1}.
  - Else: R <= Rs, Q <= Qs.
- At the edge ending iteration 31 phase 1 (E64), go to DONE:
  - Multiply: hi = PH, lo = PL (after final update).
  - Divide: hi = R, lo = Q.
  - busy = 0.
- DONE lasts one cycle with done = 1, then returns to IDLE.
  - A start seen in DONE is accepted at that edge; done still deasserts.
- hi, lo and div_zero hold their values until the next accepted start (div_zero clears at acceptance).
- ALU ports outside RUN: alu_a = alu_b = 0, alu_op = OP_IDLE.
- Latency: start accepted at E0 gives done high in cycle E64..E65 (div-by-zero: E0..E1).
- All arithmetic is modulo 2^32 on the 32-bit registers; the carry comes only from SLTU (ALU overflow is not used).

Test Plan:
- Multiply: a=7, b=6 -> done exactly 65 cycles after start is sampled; hi=0, lo=42; busy high for 64 cycles.
- Multiply: a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001. Also a=32'h80000000, b=2 -> hi=1, lo=0.
- Divide: a=100, b=7 -> lo=14, hi=2, div_zero=0. Also a=32'hFFFFFFFF, b=1 -> lo=32'hFFFFFFFF, hi=0. Also a=5, b=9 -> lo=0, hi=5.
- Divide by zero: a=123, b=0 -> done the cycle after start, hi=123, lo=32'hFFFFFFFF, div_zero=1, ALU ports idle throughout.
- Start pulsed at cycle 10 of a running multiply with different a, b -> ignored; the original result is returned. Back-to-back start held during DONE -> second operation begins with no IDLE cycle.
- rst asserted at cycle 30 of a divide -> outputs go to 0 immediately (asynchronously), alu_op = 0. After release, a new multiply 3*5 -> lo=15.
